// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential ALU.
// - alu_op_e    : 4-bit operation encoding
// - alu_state_e : handshake FSM states
// - is_iterative / is_div / is_signed_div / is_rem : opcode classification helpers
package alu_pkg;

  typedef enum logic [3:0] {
    OpAnd  = 4'b0000,
    OpOr   = 4'b0001,
    OpAdd  = 4'b0010,
    OpXor  = 4'b0011,
    OpSub  = 4'b0100,
    OpSlt  = 4'b0101,
    OpSltu = 4'b0110,
    OpSll  = 4'b0111,
    OpEq   = 4'b1000,
    OpSrl  = 4'b1001,
    OpSra  = 4'b1010,
    OpMul  = 4'b1011,
    OpDiv  = 4'b1100,
    OpDivu = 4'b1101,
    OpRem  = 4'b1110,
    OpRemu = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } alu_state_e;

  function automatic logic is_iterative(alu_op_e op);
    return op inside {OpMul, OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

  function automatic logic is_div(alu_op_e op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

  function automatic logic is_signed_div(alu_op_e op);
    return op inside {OpDiv, OpRem};
  endfunction

  function automatic logic is_rem(alu_op_e op);
    return op inside {OpRem, OpRemu};
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative multiplier / restoring divider, one step per cycle.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous abort of the running operation
//   start       : load operands and begin DATA_WIDTH iterations
//   op, a, b    : operation and operands, sampled on start
//   done        : high in the cycle of the final step
//   result      : sign-corrected result, valid while done is high
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  start,
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

  logic [CntW-1:0]       cnt_q, cnt_d;
  // MUL: acc = partial product, opa = multiplicand, opb = multiplier.
  // DIV: acc = partial remainder, opa = dividend shifting into quotient, opb = divisor.
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  alu_op_e               op_q, op_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;

  logic                  a_neg, b_neg;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic [DATA_WIDTH-1:0] step_acc, step_opa, step_opb;
  logic [DATA_WIDTH:0]   shifted, diff;

  always_comb begin
    a_neg = is_signed_div(op) & a[DATA_WIDTH-1];
    b_neg = is_signed_div(op) & b[DATA_WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One iteration of the selected algorithm.
  always_comb begin
    shifted  = {acc_q, opa_q[DATA_WIDTH-1]};
    diff     = shifted - {1'b0, opb_q};
    step_acc = acc_q;
    step_opa = opa_q;
    step_opb = opb_q;
    if (op_q == OpMul) begin
      step_acc = opb_q[0] ? acc_q + opa_q : acc_q;
      step_opa = opa_q << 1;
      step_opb = opb_q >> 1;
    end else begin
      // Restore (keep shifted) when the trial subtraction goes negative.
      step_acc = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
      step_opa = {opa_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
    end
  end

  always_comb begin
    done = (cnt_q == CntW'(1));
    if (op_q == OpMul) begin
      result = step_acc;
    end else if (is_rem(op_q)) begin
      result = neg_rem_q ? -step_acc : step_acc;
    end else begin
      result = neg_quo_q ? -step_opa : step_opa;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (flush) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d     = CntW'(DATA_WIDTH);
      acc_d     = '0;
      opa_d     = (op == OpMul) ? a : a_mag;
      opb_d     = (op == OpMul) ? b : b_mag;
      op_d      = op;
      neg_quo_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
      acc_d = step_acc;
      opa_d = step_opa;
      opb_d = step_opb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      op_q      <= OpAnd;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU behind a valid/ready handshake.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous abort, drops in-flight and pending results
//   in_valid / in_ready   : request handshake (SrcA, SrcB, Operation)
//   out_valid / out_ready : result handshake (ALUResult)
//   busy                  : iterative MUL/DIV/REM in progress
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     busy
);

  localparam int unsigned ShW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  alu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  alu_op_e               op;
  logic [ShW-1:0]        shamt;
  logic                  div_by_zero, sdiv_ovf, special, launch_iter;
  logic                  accept, start;
  logic [DATA_WIDTH-1:0] quick_result;
  logic                  md_done;
  logic [DATA_WIDTH-1:0] md_result;

  assign op    = alu_op_e'(Operation[3:0]);
  assign shamt = SrcB[ShW-1:0];

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign ALUResult = result_q;

  // flush wins over a same-cycle accept.
  assign accept = in_valid && in_ready && !flush;

  always_comb begin
    div_by_zero = (SrcB == '0);
    sdiv_ovf    = is_signed_div(op) && (SrcA == MinNeg) && (SrcB == '1);
    special     = is_div(op) && (div_by_zero || sdiv_ovf);
    launch_iter = is_iterative(op) && !special;
  end

  // Single-cycle results, including the division corner cases.
  always_comb begin
    quick_result = '0;
    unique case (op)
      OpAnd:  quick_result = SrcA & SrcB;
      OpOr:   quick_result = SrcA | SrcB;
      OpAdd:  quick_result = SrcA + SrcB;
      OpXor:  quick_result = SrcA ^ SrcB;
      OpSub:  quick_result = SrcA - SrcB;
      OpSlt:  quick_result[0] = $signed(SrcA) < $signed(SrcB);
      OpSltu: quick_result[0] = SrcA < SrcB;
      OpSll:  quick_result = SrcA << shamt;
      OpEq:   quick_result[0] = (SrcA == SrcB);
      OpSrl:  quick_result = SrcA >> shamt;
      OpSra:  quick_result = $unsigned($signed(SrcA) >>> shamt);
      OpMul:  quick_result = '0;
      // Divide by zero -> all ones; otherwise this is signed overflow -> dividend.
      OpDiv, OpDivu: quick_result = div_by_zero ? '1 : SrcA;
      // Divide by zero -> dividend; otherwise signed overflow -> 0.
      OpRem, OpRemu: quick_result = div_by_zero ? SrcA : '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    start    = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (launch_iter) begin
              state_d = BUSY;
              start   = 1'b1;
            end else begin
              state_d  = DONE;
              result_d = quick_result;
            end
          end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          if (md_done) begin
            state_d  = DONE;
            result_d = md_result;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  iter_muldiv #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iter_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .start (start),
    .op    (op),
    .a     (SrcA),
    .b     (SrcB),
    .done  (md_done),
    .result(md_result)
  );

endmodule
